// File: rtl/spike_dec_pkg.sv
// Shared types and helpers for the spike rate decoder.
// Holds the FSM state type, default sizing constants and the saturation helper.
package spike_dec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int DEF_WINDOW = 16;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_ISI_W  = 8;

  // True when a counter at value v may still step by one without passing max_v.
  function automatic logic sat_inc_ok(input logic [31:0] v, input logic [31:0] max_v, input logic inc);
    return inc && (v < max_v);
  endfunction

endpackage

// File: rtl/spike_isi_timer.sv
// Inter-spike interval timer: counts enabled cycles between spikes, saturating.
// Only instantiated when SPIKE_RATE_DECODER_ISI_EN is defined.
module spike_isi_timer
  import spike_dec_pkg::*;
#(
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic             spike,
  output logic [ISI_W-1:0] isi_o,
  output logic             isi_valid
);

  localparam logic [31:0] ISI_MAX = 32'((64'd1 << ISI_W) - 64'd1);

  logic [ISI_W-1:0] cnt_reg;
  logic             seen_reg;
  logic [ISI_W-1:0] cnt_step;

  // cnt_reg + 1 with saturation; also the interval ending on the current spike cycle.
  assign cnt_step = cnt_reg + ISI_W'(sat_inc_ok(32'(cnt_reg), ISI_MAX, 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      seen_reg  <= 1'b0;
      isi_o     <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (clear) begin
        cnt_reg  <= '0;
        seen_reg <= 1'b0;
      end else if (run) begin
        if (spike) begin
          if (seen_reg) begin
            isi_o     <= cnt_step;
            isi_valid <= 1'b1;
          end
          cnt_reg  <= '0;
          seen_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_step;
        end
      end
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes per WINDOW-cycle window and hands the count out over valid/ready.
// Define SPIKE_RATE_DECODER_ISI_EN to add inter-spike interval measurement on isi_o/isi_valid.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ISI_W  = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_o,
  output logic             rate_valid,
  input  logic             rate_ready,
  input  logic             ovr_clr,
  output logic             overrun,
  output logic [ISI_W-1:0] isi_o,
  output logic             isi_valid
);

  localparam int          IDX_W   = $clog2(WINDOW);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] acc_reg;
  logic [CNT_W-1:0] acc_next;
  logic             counting;
  logic             last_cycle;
  logic             result_free;

  assign acc_next    = acc_reg + CNT_W'(sat_inc_ok(32'(acc_reg), CNT_MAX, spike_in));
  assign counting    = (state_reg == ACCUM) && en;
  assign last_cycle  = counting && (idx_reg == IDX_W'(WINDOW - 1));
  // A new result may overwrite the output only if the slot is empty or being drained now.
  assign result_free = !rate_valid || rate_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      acc_reg    <= '0;
      rate_o     <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          idx_reg <= '0;
          acc_reg <= '0;
          if (en) state_reg <= ACCUM;
        end
        ACCUM: begin
          if (!en) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            acc_reg   <= '0;
          end else if (last_cycle) begin
            idx_reg <= '0;
            acc_reg <= '0;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
            acc_reg <= acc_next;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (last_cycle && result_free) begin
        rate_o     <= acc_next;
        rate_valid <= 1'b1;
      end else if (rate_valid && rate_ready) begin
        rate_valid <= 1'b0;
      end

      if (last_cycle && !result_free) overrun <= 1'b1;
      else if (ovr_clr)               overrun <= 1'b0;
    end
  end

`ifdef SPIKE_RATE_DECODER_ISI_EN
  spike_isi_timer #(
    .ISI_W(ISI_W)
  ) u_isi (
    .clk       (clk),
    .rst       (rst),
    .run       (counting),
    .clear     ((state_reg == ACCUM) && !en),
    .spike     (spike_in),
    .isi_o     (isi_o),
    .isi_valid (isi_valid)
  );
`else
  assign isi_o     = '0;
  assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: expected window counts are queued by the stimulus
// and popped by monitors on each rate handshake; a CNT_W=3 instance covers saturation.
module tb_spike_rate_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, spike_in, rate_ready, ovr_clr;
  logic [7:0] rate_o;
  logic       rate_valid, overrun;
  logic [7:0] isi_o;
  logic       isi_valid;

  logic       en2, spike2;
  logic [2:0] rate2;
  logic       valid2, ovr2;
  logic [7:0] isi2;
  logic       isiv2;

  int n_cmp = 0;
  int n_bad = 0;
  int q1[$];
  int q2[$];

  spike_rate_decoder #(.WINDOW(16), .CNT_W(8), .ISI_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rate_o(rate_o), .rate_valid(rate_valid), .rate_ready(rate_ready),
    .ovr_clr(ovr_clr), .overrun(overrun), .isi_o(isi_o), .isi_valid(isi_valid)
  );

  spike_rate_decoder #(.WINDOW(16), .CNT_W(3), .ISI_W(8)) dut_sat (
    .clk(clk), .rst(rst), .en(en2), .spike_in(spike2),
    .rate_o(rate2), .rate_valid(valid2), .rate_ready(rate_ready),
    .ovr_clr(ovr_clr), .overrun(ovr2), .isi_o(isi2), .isi_valid(isiv2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: one popped expectation per accepted result.
  always @(negedge clk) begin
    int e;
    if (!rst && rate_valid && rate_ready) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rate_unexpected: got %0d, expected no result", rate_o);
      end else begin
        e = q1.pop_front();
        $display("xfer dut     rate=%0d expected=%0d", rate_o, e);
        check("rate", int'(rate_o), e);
      end
    end
  end

  always @(negedge clk) begin
    int e;
    if (!rst && valid2 && rate_ready) begin
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rate_sat_unexpected: got %0d, expected no result", rate2);
      end else begin
        e = q2.pop_front();
        $display("xfer dut_sat rate=%0d expected=%0d", rate2, e);
        check("rate_sat", int'(rate2), e);
      end
    end
  end

  task automatic run_window(input logic [15:0] pat);
    for (int k = 0; k < 16; k++) begin
      spike_in = pat[k];
      tick();
    end
    spike_in = 1'b0;
  endtask

  task automatic run_window2(input logic [15:0] pat);
    for (int k = 0; k < 16; k++) begin
      spike2 = pat[k];
      tick();
    end
    spike2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; spike_in = 1'b1; rate_ready = 1'b1; ovr_clr = 1'b0;
    en2 = 1'b1; spike2 = 1'b1;
    repeat (3) tick();
    rst = 1'b0; en = 1'b0; spike_in = 1'b0; en2 = 1'b0; spike2 = 1'b0;
    check("reset_rate_valid", int'(rate_valid), 0);
    check("reset_rate_o", int'(rate_o), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_sat_valid", int'(valid2), 0);
    tick();

    // Back-to-back windows, ready held high.
    q1.push_back(4); q1.push_back(4); q1.push_back(4); q1.push_back(2);
    en = 1'b1;
    tick();
    run_window(16'h1111);
    run_window(16'h1111);
    run_window(16'h1111);
    run_window(16'hC000);
    check("rate_valid_rise", int'(rate_valid), 1);
    tick();
    check("rate_valid_fall", int'(rate_valid), 0);
    en = 1'b0;
    tick();
    check("isi_idle_o", int'(isi_o), 0);
    check("isi_idle_valid", int'(isi_valid), 0);

    // Consumer stalled over two windows.
    rate_ready = 1'b0;
    en = 1'b1;
    tick();
    q1.push_back(3);
    run_window(16'h0007);
    run_window(16'h001F);
    check("held_rate_o", int'(rate_o), 3);
    check("held_rate_valid", int'(rate_valid), 1);
    check("overrun_set", int'(overrun), 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("overrun_cleared", int'(overrun), 0);
    check("held_rate_o_after_clr", int'(rate_o), 3);
    en = 1'b0;
    rate_ready = 1'b1;
    tick();
    tick();
    check("drained_rate_valid", int'(rate_valid), 0);

    // Window aborted at cycle 10.
    en = 1'b1;
    tick();
    spike_in = 1'b1;
    repeat (10) tick();
    en = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_result", int'(rate_valid), 0);
    end
    spike_in = 1'b0;
    en = 1'b1;
    tick();
    q1.push_back(2);
    run_window(16'h0101);
    tick();
    en = 1'b0;
    tick();

    // Saturating count with CNT_W=3.
    q2.push_back(7); q2.push_back(6);
    en2 = 1'b1;
    tick();
    run_window2(16'hFFFF);
    run_window2(16'h003F);
    tick();
    en2 = 1'b0;
    tick();

`ifdef SPIKE_RATE_DECODER_ISI_EN
    en = 1'b1;
    tick();
    q1.push_back(2);
    for (int k = 0; k < 16; k++) begin
      spike_in = (k == 5 || k == 12);
      tick();
      if (k == 5)  check("isi_first_no_pulse", int'(isi_valid), 0);
      if (k == 12) begin
        check("isi_pulse", int'(isi_valid), 1);
        check("isi_value_7", int'(isi_o), 7);
      end
      if (k == 13) check("isi_pulse_end", int'(isi_valid), 0);
    end
    spike_in = 1'b0;
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    q1.push_back(1);
    for (int w = 0; w < 17; w++) q1.push_back(0);
    q1.push_back(1);
    for (int k = 0; k < 304; k++) begin
      spike_in = (k == 0 || k == 300);
      tick();
      if (k == 0) check("isi_restart_no_pulse", int'(isi_valid), 0);
      if (k == 300) begin
        check("isi_sat_pulse", int'(isi_valid), 1);
        check("isi_sat_255", int'(isi_o), 255);
      end
    end
    spike_in = 1'b0;
    tick();
    en = 1'b0;
    tick();
`else
    check("isi_off_o", int'(isi_o), 0);
    check("isi_off_valid", int'(isi_valid), 0);
`endif

    for (int i = 0; i < 40 && (q1.size() + q2.size()) != 0; i++) tick();
    check("scoreboard_drained", q1.size() + q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
